// File: rtl/vp_pkg.sv
// Shared types and sizing helpers for the value-prediction feedback queue.
package vp_pkg;

  // One tracked prediction: the instruction pc, the predicted value and the
  // saturated-confidence bit that vp_wrapper reported when it issued it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        conf;
  } vp_entry_t;

  localparam int VP_NUM_PRED_DEF = 2;
  localparam int VP_DEPTH_DEF    = 32;

  // Pointer width for a power-of-two queue depth.
  function automatic int vp_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so a full queue (count == depth) is representable.
  function automatic int vp_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width needed to hold a lane count in the range 0..lanes.
  function automatic int vp_lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/vp_lane_compact.sv
// Valid-lane compaction: for each lane, the number of valid lanes below it
// (its write offset from the tail) plus the total number of valid lanes.
module vp_lane_compact
  import vp_pkg::*;
#(
  parameter int P_NUM_PRED = VP_NUM_PRED_DEF,
  parameter int P_OFF_W    = vp_lane_cnt_w(P_NUM_PRED)
) (
  input  logic [P_NUM_PRED-1:0]              valid_i,
  output logic [P_NUM_PRED-1:0][P_OFF_W-1:0] offset_o,
  output logic [P_OFF_W-1:0]                 total_o
);

  logic [P_OFF_W-1:0] run_c;

  // Running prefix count of valid bits, lane 0 first.
  always_comb begin
    run_c    = '0;
    offset_o = '0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      offset_o[i] = run_c;
      if (valid_i[i]) begin
        run_c = run_c + P_OFF_W'(1);
      end
    end
    total_o = run_c;
  end

endmodule

// File: rtl/vp_feedback_queue.sv
// In-order tracking queue between vp_wrapper's prediction output and its
// training (fb_*) input. Predictions are pushed in lane order, executed
// results pop them in program order, and each matched pair is compared and
// reported one cycle later. A pc disagreement at the head means the queue
// has lost sync with the pipeline, so it drops everything and pulses desync_o.
//
// Handshake: pred_ready_o is a whole-group ready computed from the registered
// occupancy only; a push group is taken in full when pred_ready_o is high and
// dropped in full when it is low (upstream must hold off). The execute side
// has no back-pressure; ex_valid_i lanes are consumed as presented.
module vp_feedback_queue
  import vp_pkg::*;
#(
  parameter int P_NUM_PRED = VP_NUM_PRED_DEF,
  parameter int P_DEPTH    = VP_DEPTH_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [P_NUM_PRED-1:0][31:0]      pred_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]      pred_result_i,
  input  logic [P_NUM_PRED-1:0]            pred_conf_i,
  input  logic [P_NUM_PRED-1:0]            pred_valid_i,
  output logic                             pred_ready_o,
  input  logic [P_NUM_PRED-1:0][31:0]      ex_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]      ex_actual_i,
  input  logic [P_NUM_PRED-1:0]            ex_valid_i,
  input  logic                             flush_i,
  output logic [P_NUM_PRED-1:0][31:0]      fb_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]      fb_actual_o,
  output logic [P_NUM_PRED-1:0]            fb_mispredict_o,
  output logic [P_NUM_PRED-1:0]            fb_conf_o,
  output logic [P_NUM_PRED-1:0]            fb_valid_o,
  output logic                             desync_o,
  output logic [vp_cnt_w(P_DEPTH)-1:0]     count_o
);

  localparam int PTR_W = vp_ptr_w(P_DEPTH);
  localparam int CNT_W = vp_cnt_w(P_DEPTH);
  localparam int OFF_W = vp_lane_cnt_w(P_NUM_PRED);

  // Queue state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  vp_entry_t        mem_q [P_DEPTH];

  // Push side
  logic [P_NUM_PRED-1:0][OFF_W-1:0] push_off;
  logic [OFF_W-1:0]                 push_total;
  logic                             push_en;
  logic [OFF_W-1:0]                 push_n;

  // Execute / compare side
  vp_entry_t                   rd_c;
  logic                        ex_live_c;
  logic [OFF_W-1:0]            pop_n;
  logic                        desync_d;
  logic                        desync_q;
  logic [P_NUM_PRED-1:0][31:0] fb_pc_d, fb_actual_d;
  logic [P_NUM_PRED-1:0]       fb_mispredict_d, fb_conf_d, fb_valid_d;
  logic [P_NUM_PRED-1:0][31:0] fb_pc_q, fb_actual_q;
  logic [P_NUM_PRED-1:0]       fb_mispredict_q, fb_conf_q, fb_valid_q;

  // Ready uses only the registered count: no credit for same-cycle pops.
  assign pred_ready_o = (CNT_W'(P_DEPTH) - count_q) >= CNT_W'(P_NUM_PRED);

  vp_lane_compact #(
    .P_NUM_PRED (P_NUM_PRED),
    .P_OFF_W    (OFF_W)
  ) u_push_compact (
    .valid_i  (pred_valid_i),
    .offset_o (push_off),
    .total_o  (push_total)
  );

  // A push group lands only when accepted and not wiped by flush or desync.
  assign push_en = pred_ready_o & ~flush_i & ~desync_d;
  assign push_n  = push_en ? push_total : '0;

  // Storage write: compacted valid lanes go to tail, tail+1, ... (wrapping).
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      if (push_en && pred_valid_i[i]) begin
        mem_q[tail_q + PTR_W'(push_off[i])] <= '{pc:     pred_pc_i[i],
                                                 result: pred_result_i[i],
                                                 conf:   pred_conf_i[i]};
      end
    end
  end

  // Pair ex lane i with entry head+i; stop at the first invalid ex lane, the
  // first lane past the occupancy, or the first pc mismatch (which desyncs).
  always_comb begin
    rd_c            = '0;
    ex_live_c       = 1'b1;
    pop_n           = '0;
    desync_d        = 1'b0;
    fb_pc_d         = '0;
    fb_actual_d     = '0;
    fb_mispredict_d = '0;
    fb_conf_d       = '0;
    fb_valid_d      = '0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      rd_c = mem_q[head_q + PTR_W'(i)];
      if (!ex_valid_i[i] || (CNT_W'(i) >= count_q)) begin
        ex_live_c = 1'b0;
      end
      if (ex_live_c) begin
        if (rd_c.pc == ex_pc_i[i]) begin
          pop_n              = pop_n + OFF_W'(1);
          fb_valid_d[i]      = 1'b1;
          fb_pc_d[i]         = rd_c.pc;
          fb_actual_d[i]     = ex_actual_i[i];
          fb_conf_d[i]       = rd_c.conf;
          fb_mispredict_d[i] = (rd_c.result != ex_actual_i[i]);
        end else begin
          desync_d  = 1'b1;
          ex_live_c = 1'b0;
        end
      end
    end
  end

  // Next pointers/occupancy: flush beats desync clear beats normal push/pop.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush_i || desync_d) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Registered feedback and desync pulse; a flush cycle reports nothing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fb_pc_q         <= '0;
      fb_actual_q     <= '0;
      fb_mispredict_q <= '0;
      fb_conf_q       <= '0;
      fb_valid_q      <= '0;
      desync_q        <= 1'b0;
    end else if (flush_i) begin
      fb_pc_q         <= '0;
      fb_actual_q     <= '0;
      fb_mispredict_q <= '0;
      fb_conf_q       <= '0;
      fb_valid_q      <= '0;
      desync_q        <= 1'b0;
    end else begin
      fb_pc_q         <= fb_pc_d;
      fb_actual_q     <= fb_actual_d;
      fb_mispredict_q <= fb_mispredict_d;
      fb_conf_q       <= fb_conf_d;
      fb_valid_q      <= fb_valid_d;
      desync_q        <= desync_d;
    end
  end

  assign fb_pc_o         = fb_pc_q;
  assign fb_actual_o     = fb_actual_q;
  assign fb_mispredict_o = fb_mispredict_q;
  assign fb_conf_o       = fb_conf_q;
  assign fb_valid_o      = fb_valid_q;
  assign desync_o        = desync_q;
  assign count_o         = count_q;

endmodule
